// File: rtl/periph_slave_responder.sv
// Slave endpoint for one peripheral crossbar output port.
// Grants incoming requests and returns one response per grant that echoes
// the requester ID. A byte-writable register bank backs the accesses.
// Index 0 is a read-only identification word. An optional number of wait
// states can be inserted between the grant and the response. Only one
// transaction is outstanding at any time.
module periph_slave_responder #(
    parameter int          ADDR_WIDTH   = 32,
    parameter int          DATA_WIDTH   = 32,
    parameter int          BE_WIDTH     = DATA_WIDTH / 8,
    parameter int          ID_WIDTH     = 9,
    parameter int          NB_REGS      = 16,
    parameter int          OFFSET_WIDTH = 10,
    parameter int          WAIT_CYCLES  = 0,
    parameter logic [31:0] PERIPH_ID    = 32'hA5A5_0001
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          req_i,
    input  logic [ADDR_WIDTH-1:0]         add_i,
    input  logic                          wen_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    input  logic [BE_WIDTH-1:0]           be_i,
    input  logic [ID_WIDTH-1:0]           id_i,
    output logic                          gnt_o,
    output logic                          r_valid_o,
    output logic [DATA_WIDTH-1:0]         r_rdata_o,
    output logic                          r_opc_o,
    output logic [ID_WIDTH-1:0]           r_id_o,
    output logic [NB_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int         IDX_W     = (NB_REGS > 1) ? $clog2(NB_REGS) : 1;
    // The counter is loaded with WAIT_CYCLES-1, so the wait state lasts exactly WAIT_CYCLES cycles.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_r;
    logic [3:0]              cnt_r;
    logic [DATA_WIDTH-1:0]   regs_r [1:NB_REGS-1];

    logic [OFFSET_WIDTH-1:0] off_s;
    logic [IDX_W-1:0]        idx_low_s;
    logic                    err_s;
    logic                    gnt_s;
    logic                    wr_en_s;
    logic [DATA_WIDTH-1:0]   rd_val_s;

    // An access is rejected for three reasons:
    // - the offset is misaligned;
    // - the index is outside the register bank;
    // - the access is a write to the read-only identification word.
    function automatic logic decode_err(input logic [OFFSET_WIDTH-1:0] off, input logic wen);
        logic [31:0] idx_ext;
        idx_ext = 32'(off[OFFSET_WIDTH-1:2]);
        return (off[1:0] != 2'b00) || (idx_ext >= 32'(NB_REGS)) ||
               (!wen && (idx_ext == 32'd0));
    endfunction

    // Only the window offset matters here; the crossbar has already routed on the upper address bits.
    assign off_s     = add_i[OFFSET_WIDTH-1:0];
    assign idx_low_s = off_s[IDX_W+1:2];
    assign err_s     = decode_err(off_s, wen_i);

    // A grant is possible whenever no response is pending. It is forced low during reset.
    assign gnt_s   = rst_ni && req_i && (state_r != ST_WAIT);
    assign gnt_o   = gnt_s;
    assign wr_en_s = gnt_s && !wen_i && !err_s;

    // Read data mux: the bank value as seen before any same-cycle write.
    always_comb begin
        rd_val_s = PERIPH_ID;
        for (int i = 1; i < NB_REGS; i++) begin
            if (idx_low_s == IDX_W'(i)) begin
                rd_val_s = regs_r[i];
            end else begin
                rd_val_s = rd_val_s;
            end
        end
    end

    // Flatten the bank for observation; slice 0 is always the identification word.
    always_comb begin
        regs_o = {(NB_REGS*DATA_WIDTH){1'b0}};
        regs_o[DATA_WIDTH-1:0] = PERIPH_ID;
        for (int i = 1; i < NB_REGS; i++) begin
            regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_r[i];
        end
    end

    // Register bank: writes take effect per enabled byte at the grant clock edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 1; i < NB_REGS; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            for (int i = 1; i < NB_REGS; i++) begin
                for (int k = 0; k < BE_WIDTH; k++) begin
                    if ((idx_low_s == IDX_W'(i)) && be_i[k]) begin
                        regs_r[i][k*8 +: 8] <= wdata_i[k*8 +: 8];
                    end
                end
            end
        end
    end

    // Response FSM: captures the response at the grant, then waits, then pulses r_valid_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            r_valid_o <= 1'b0;
            r_rdata_o <= {DATA_WIDTH{1'b0}};
            r_opc_o   <= 1'b0;
            r_id_o    <= {ID_WIDTH{1'b0}};
        end else begin
            r_valid_o <= 1'b0;
            case (state_r)
                ST_IDLE, ST_RESP: begin
                    if (gnt_s) begin
                        r_id_o    <= id_i;
                        r_opc_o   <= err_s;
                        r_rdata_o <= (wen_i && !err_s) ? rd_val_s : {DATA_WIDTH{1'b0}};
                        if (WAIT_CYCLES == 0) begin
                            state_r   <= ST_RESP;
                            r_valid_o <= 1'b1;
                        end else begin
                            cnt_r   <= WAIT_LOAD;
                            state_r <= ST_WAIT;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r   <= ST_RESP;
                        r_valid_o <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_periph_slave_responder.sv
// Directed bench for periph_slave_responder.
// Instance a is built with zero wait states and instance b with three.
module tb_periph_slave_responder;

    logic clk;
    int   total;
    int   bad;

    logic         a_rst_n, a_req, a_wen, a_gnt, a_rvalid, a_opc;
    logic [31:0]  a_add, a_wdata, a_rdata;
    logic [3:0]   a_be;
    logic [8:0]   a_id, a_rid;
    logic [511:0] a_regs;

    logic         b_rst_n, b_req, b_wen, b_gnt, b_rvalid, b_opc;
    logic [31:0]  b_add, b_wdata, b_rdata;
    logic [3:0]   b_be;
    logic [8:0]   b_id, b_rid;
    logic [511:0] b_regs;

    logic [511:0] snap;

    periph_slave_responder #(.WAIT_CYCLES(0)) dut_a (
        .clk_i(clk), .rst_ni(a_rst_n), .req_i(a_req), .add_i(a_add), .wen_i(a_wen),
        .wdata_i(a_wdata), .be_i(a_be), .id_i(a_id), .gnt_o(a_gnt), .r_valid_o(a_rvalid),
        .r_rdata_o(a_rdata), .r_opc_o(a_opc), .r_id_o(a_rid), .regs_o(a_regs)
    );

    periph_slave_responder #(.WAIT_CYCLES(3)) dut_b (
        .clk_i(clk), .rst_ni(b_rst_n), .req_i(b_req), .add_i(b_add), .wen_i(b_wen),
        .wdata_i(b_wdata), .be_i(b_be), .id_i(b_id), .gnt_o(b_gnt), .r_valid_o(b_rvalid),
        .r_rdata_o(b_rdata), .r_opc_o(b_opc), .r_id_o(b_rid), .regs_o(b_regs)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction on instance a: starts just after a rising edge and checks the grant and the response.
    task automatic txn_a(input logic [31:0] add, input logic wen, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [8:0] id,
                         input logic [31:0] exp_rdata, input logic exp_opc);
        a_req = 1'b1; a_add = add; a_wen = wen; a_wdata = wdata; a_be = be; a_id = id;
        #2;
        check_val("a_gnt", a_gnt, 1'b1);
        @(posedge clk); #1;
        a_req = 1'b0;
        check_val("a_rvalid", a_rvalid, 1'b1);
        check_val("a_rdata", a_rdata, exp_rdata);
        check_val("a_opc", a_opc, exp_opc);
        check_val("a_rid", a_rid, id);
    endtask

    initial begin
        total = 0; bad = 0;
        a_rst_n = 1'b0; a_req = 1'b1; a_add = 32'd0; a_wen = 1'b1; a_wdata = 32'd0; a_be = 4'd0; a_id = 9'd0;
        b_rst_n = 1'b0; b_req = 1'b0; b_add = 32'd0; b_wen = 1'b1; b_wdata = 32'd0; b_be = 4'd0; b_id = 9'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        // Reset state, with a request held to show the grant stays low.
        check_val("rst_gnt", a_gnt, 1'b0);
        check_val("rst_rvalid", a_rvalid, 1'b0);
        check_val("rst_rdata", a_rdata, 32'd0);
        check_val("rst_opc", a_opc, 1'b0);
        check_val("rst_rid", a_rid, 9'd0);
        check_val("rst_regs0", a_regs[31:0], 32'hA5A5_0001);
        check_val("rst_regs1", a_regs[63:32], 32'd0);
        a_req = 1'b0;
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        @(posedge clk); #1;

        // Identification read.
        txn_a(32'h000, 1'b1, 32'd0, 4'h0, 9'h05, 32'hA5A5_0001, 1'b0);
        @(posedge clk); #1;
        check_val("rvalid_pulse", a_rvalid, 1'b0);
        check_val("rdata_hold", a_rdata, 32'hA5A5_0001);

        // Byte-enabled write, then read back; also a read through aliased upper address bits.
        txn_a(32'h004, 1'b0, 32'hDEAD_BEEF, 4'b0101, 9'h11, 32'd0, 1'b0);
        check_val("wr_regs1", a_regs[63:32], 32'h00AD_00EF);
        txn_a(32'h004, 1'b1, 32'd0, 4'h0, 9'h12, 32'h00AD_00EF, 1'b0);
        txn_a(32'hFFFF_F404, 1'b1, 32'd0, 4'hF, 9'h13, 32'h00AD_00EF, 1'b0);

        // Error cases leave the bank untouched.
        snap = a_regs;
        txn_a(32'h000, 1'b0, 32'hFFFF_FFFF, 4'hF, 9'h21, 32'd0, 1'b1);
        txn_a(32'h040, 1'b1, 32'd0, 4'hF, 9'h22, 32'd0, 1'b1);
        txn_a(32'h006, 1'b1, 32'd0, 4'hF, 9'h23, 32'd0, 1'b1);
        txn_a(32'h044, 1'b0, 32'h1234_5678, 4'hF, 9'h24, 32'd0, 1'b1);
        check_val("err_regs", a_regs, snap);

        // Fill registers 2..4; a zero byte-enable write is a clean no-op.
        txn_a(32'h008, 1'b0, 32'h2222_2222, 4'hF, 9'h31, 32'd0, 1'b0);
        txn_a(32'h00C, 1'b0, 32'h3333_3333, 4'hF, 9'h32, 32'd0, 1'b0);
        txn_a(32'h010, 1'b0, 32'h4444_4444, 4'hF, 9'h33, 32'd0, 1'b0);
        txn_a(32'h008, 1'b0, 32'hFFFF_FFFF, 4'h0, 9'h34, 32'd0, 1'b0);
        check_val("be0_regs2", a_regs[95:64], 32'h2222_2222);

        // Back-to-back reads of idx 1..4 with one grant per cycle.
        for (int i = 1; i <= 4; i++) begin
            logic [31:0] exp_d;
            case (i)
                1:       exp_d = 32'h00AD_00EF;
                2:       exp_d = 32'h2222_2222;
                3:       exp_d = 32'h3333_3333;
                default: exp_d = 32'h4444_4444;
            endcase
            a_req = 1'b1; a_wen = 1'b1; a_add = 32'(i * 4); a_id = 9'(i);
            #2;
            check_val("b2b_gnt", a_gnt, 1'b1);
            @(posedge clk); #1;
            check_val("b2b_rvalid", a_rvalid, 1'b1);
            check_val("b2b_rid", a_rid, 9'(i));
            check_val("b2b_rdata", a_rdata, exp_d);
        end
        a_req = 1'b0;
        @(posedge clk); #1;
        check_val("b2b_end", a_rvalid, 1'b0);

        // Three wait states: two reads with the request held.
        // The grants are expected in cycles 0 and 4, and the responses in cycles 4 and 8.
        b_req = 1'b1; b_wen = 1'b1; b_add = 32'h000; b_id = 9'h07;
        for (int c = 0; c < 10; c++) begin
            if (c == 1) b_id = 9'h08;
            if (c == 8) b_req = 1'b0;
            check_val("ws_rvalid", b_rvalid, (c == 4 || c == 8) ? 1'b1 : 1'b0);
            if (c == 4) check_val("ws_rid1", b_rid, 9'h07);
            if (c == 8) check_val("ws_rid2", b_rid, 9'h08);
            if (c == 8) check_val("ws_rdata", b_rdata, 32'hA5A5_0001);
            #2;
            check_val("ws_gnt", b_gnt, (c == 0 || c == 4) ? 1'b1 : 1'b0);
            @(posedge clk); #1;
        end

        // A reset while waiting drops the pending response and clears the write.
        b_req = 1'b1; b_wen = 1'b0; b_add = 32'h008; b_wdata = 32'h1234_5678; b_be = 4'hF; b_id = 9'h03;
        #2;
        check_val("rw_gnt", b_gnt, 1'b1);
        @(posedge clk); #1;
        b_req = 1'b0;
        check_val("rw_regs2", b_regs[95:64], 32'h1234_5678);
        @(posedge clk); #1;
        b_rst_n = 1'b0;
        #1;
        check_val("rw_rst_rvalid", b_rvalid, 1'b0);
        check_val("rw_rst_rdata", b_rdata, 32'd0);
        check_val("rw_rst_opc", b_opc, 1'b0);
        check_val("rw_rst_rid", b_rid, 9'd0);
        check_val("rw_rst_gnt", b_gnt, 1'b0);
        check_val("rw_rst_regs2", b_regs[95:64], 32'd0);
        @(posedge clk); #1;
        b_rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check_val("rw_no_resp", b_rvalid, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/periph_slave_responder.md
Name: periph_slave_responder

Overview:
- Generic slave endpoint for one output port of the cluster peripheral crossbar (the XBAR_PERIPH_BUS slave side, i.e. the far end of a speriph_master link).
- Accepts req/add/wen/wdata/be/id, grants, and returns exactly one response carrying the echoed ID.
- Backs the transactions with a small byte-writable register bank; a read-only identification word sits at index 0.
- Wait states are configurable; at most one transaction is outstanding.

Parameters:
ADDR_WIDTH, 32, request address width
DATA_WIDTH, 32, data width (fixed 32 in this cluster)
BE_WIDTH, DATA_WIDTH/8, byte-enable width
ID_WIDTH, 9, transaction ID width (NB_CORES+NB_MPERIPHS)
NB_REGS, 16, number of 32-bit registers, index 0 read-only; power of two, 2..256
OFFSET_WIDTH, 10, address bits decoded inside the peripheral window
WAIT_CYCLES, 0, extra stall cycles between grant and response, 0..15
PERIPH_ID, 32'hA5A5_0001, value returned when index 0 is read

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
req_i  in  1  request valid
add_i  in  ADDR_WIDTH  byte address
wen_i  in  1  1 = read, 0 = write
wdata_i  in  DATA_WIDTH  write data
be_i  in  BE_WIDTH  byte enables
id_i  in  ID_WIDTH  requester ID
gnt_o  out  1  request accepted this cycle
r_valid_o  out  1  response valid (one-cycle pulse)
r_rdata_o  out  DATA_WIDTH  read data
r_opc_o  out  1  1 = error
r_id_o  out  ID_WIDTH  echoed id_i of the granted request
regs_o  out  NB_REGS*DATA_WIDTH  flat register contents, index i at bits [i*32+:32]; slice 0 = PERIPH_ID

Behaviour:
- Reset (async, rst_ni=0):
  - registers 1..NB_REGS-1 = 0; state = IDLE.
  - gnt_o=0, r_valid_o=0, r_rdata_o=0, r_opc_o=0, r_id_o=0.
  - Any pending response is dropped and never issued.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: gnt_o = req_i (combinational). On grant: capture id, rdata and error; if WAIT_CYCLES=0 go to RESP, else load counter = WAIT_CYCLES-1 and go to WAIT.
  - WAIT: gnt_o=0; decrement the counter; go to RESP when counter=0 (stays exactly WAIT_CYCLES cycles).
  - RESP: r_valid_o=1 with the captured r_rdata_o/r_opc_o/r_id_o. gnt_o = req_i, so back-to-back grants are allowed; this follows the same rules as IDLE. Otherwise go to IDLE.
- Response latency: r_valid_o rises exactly WAIT_CYCLES+1 cycles after the grant cycle. With WAIT_CYCLES=0, 1 transaction/cycle throughput.
- The response registers hold their values outside the r_valid_o pulse. r_valid_o is low in every cycle that is not RESP.
- Decode:
  - off = add_i[OFFSET_WIDTH-1:0]; idx = off[OFFSET_WIDTH-1:2].
  - Error if off[1:0]!=0, or idx>=NB_REGS, or (write and idx==0).
  - Upper address bits above OFFSET_WIDTH are ignored (routing already done by the crossbar).
- Write (wen_i=0), granted, no error:
  - reg[idx] byte k <= wdata_i byte k for each be_i[k]=1, at the grant clock edge.
  - be_i=0 is a legal no-op with r_opc_o=0.
  - Write response: r_rdata_o=0.
- Read (wen_i=1), granted, no error:
  - r_rdata_o = register value before any write in the same cycle.
  - be_i is ignored.
- Any error: no state change, r_rdata_o=0, r_opc_o=1, ID still echoed.
- req_i may drop without a grant (only possible in WAIT); nothing is recorded.
- Inputs are sampled only in the grant cycle.

Test Plan:
- Reset, then read idx0 (add 0x000, id 0x05), WAIT_CYCLES=0 -> gnt in the same cycle; next cycle r_valid=1, rdata=0xA5A50001, opc=0, r_id=0x05.
- Write 0xDEADBEEF to 0x004 with be=4'b0101, then read 0x004 -> rdata=0x00AD00EF, opc=0.
- Error cases, each -> opc=1, rdata=0, regs_o unchanged:
  - write to 0x000;
  - read 0x040 (NB_REGS=16);
  - read 0x006 (misaligned).
- WAIT_CYCLES=3, req held for two back-to-back reads:
  - grants at cycles 0 and 4; r_valid pulses at cycles 4 and 8;
  - gnt=0 during cycles 1-3 and 5-7.
- WAIT_CYCLES=0, continuous reads of idx 1..4 with ids 1..4 -> gnt every cycle; r_valid high for 4 consecutive cycles; ids returned in order 1..4.
- WAIT_CYCLES=3, write idx 2 then assert rst_ni=0 during WAIT -> no r_valid ever; all outputs 0; regs_o slice 2 = 0.
